sram_port_arbiter: RTL and testbench

//  Shares one SRAM-like memory port between the CPU instruction fetch port and data port.
//  It sits between mips_top (after address translation) and the cache/AXI bridge.
//  It sequences at most one transaction per source per pipeline-stall period and drives

---
 rtl/sram_port_arbiter.sv | 131 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Arbitrates the CPU fetch and data SRAM ports onto a single downstream request/response port.
// Data has fixed priority; each source is served at most once per pipeline-stall period.
module sram_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                inst_sram_en,
    input  logic [ADDR_W-1:0]   inst_sram_addr,
    output logic [DATA_W-1:0]   inst_sram_rdata,
    output logic                inst_stall,
    input  logic                data_sram_en,
    input  logic [DATA_W/8-1:0] data_sram_wen,
    input  logic [ADDR_W-1:0]   data_sram_addr,
    input  logic [DATA_W-1:0]   data_sram_wdata,
    input  logic                no_dcache,
    output logic [DATA_W-1:0]   data_sram_rdata,
    output logic                data_stall,
    input  logic                longest_stall,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_uncached,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {S_IDLE, S_D_ADDR, S_D_WAIT, S_I_ADDR, S_I_WAIT} state_t;

    state_t              r_state, w_next;
    logic                r_inst_done, r_data_done;
    logic                r_wr, r_unc;
    logic [STRB_W-1:0]   r_wstrb;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata, r_inst_rdata, r_data_rdata;
    logic                w_issue_d, w_issue_i, w_fin_d, w_fin_i;

    assign w_issue_d = (r_state == S_IDLE) & data_sram_en & ~r_data_done;
    assign w_issue_i = (r_state == S_IDLE) & ~w_issue_d & inst_sram_en & ~r_inst_done;
    assign w_fin_d   = (r_state == S_D_WAIT) & mem_data_ok;
    assign w_fin_i   = (r_state == S_I_WAIT) & mem_data_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_issue_d)      w_next = S_D_ADDR;
                else if (w_issue_i) w_next = S_I_ADDR;
            end
            S_D_ADDR: if (mem_addr_ok) w_next = S_D_WAIT;
            S_D_WAIT: if (mem_data_ok) w_next = S_IDLE;
            S_I_ADDR: if (mem_addr_ok) w_next = S_I_WAIT;
            S_I_WAIT: if (mem_data_ok) w_next = S_IDLE;
            default:                   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req = 1'b0;
        case (r_state)
            S_D_ADDR, S_I_ADDR: mem_req = 1'b1;
            default:            mem_req = 1'b0;
        endcase
    end

    // Request fields are captured once in IDLE so they stay stable until accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_wstrb <= '0;
            r_wdata <= '0;
            r_unc   <= 1'b0;
        end else if (w_issue_d) begin
            r_addr  <= data_sram_addr;
            r_wr    <= |data_sram_wen;
            r_wstrb <= data_sram_wen;
            r_wdata <= data_sram_wdata;
            r_unc   <= no_dcache;
        end else if (w_issue_i) begin
            r_addr  <= inst_sram_addr;
            r_wr    <= 1'b0;
            r_wstrb <= '0;
            r_wdata <= '0;
            r_unc   <= 1'b0;
        end
    end

    // Completion beats the pipeline-advance clear when both land on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inst_done <= 1'b0;
            r_data_done <= 1'b0;
        end else begin
            if (w_fin_i)             r_inst_done <= 1'b1;
            else if (!longest_stall) r_inst_done <= 1'b0;
            if (w_fin_d)             r_data_done <= 1'b1;
            else if (!longest_stall) r_data_done <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            if (w_fin_i)          r_inst_rdata <= mem_rdata;
            if (w_fin_d && !r_wr) r_data_rdata <= mem_rdata;
        end
    end

    assign inst_sram_rdata = r_inst_rdata;
    assign data_sram_rdata = r_data_rdata;
    assign inst_stall      = resetn & inst_sram_en & ~r_inst_done;
    assign data_stall      = resetn & data_sram_en & ~r_data_done;
    assign mem_wr          = r_wr;
    assign mem_wstrb       = r_wstrb;
    assign mem_addr        = r_addr;
    assign mem_wdata       = r_wdata;
    assign mem_uncached    = r_unc;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench: stimulus queues expected downstream requests and load results;
// a downstream responder and a stall monitor pop and compare independently.
module tb_sram_port_arbiter;
    logic        clk, resetn;
    logic        inst_sram_en, data_sram_en, no_dcache, longest_stall;
    logic [31:0] inst_sram_addr, data_sram_addr, data_sram_wdata;
    logic [3:0]  data_sram_wen;
    logic [31:0] inst_sram_rdata, data_sram_rdata;
    logic        inst_stall, data_stall;
    logic        mem_req, mem_wr, mem_uncached, mem_addr_ok, mem_data_ok;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
        .inst_sram_rdata(inst_sram_rdata), .inst_stall(inst_stall),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .no_dcache(no_dcache), .data_sram_rdata(data_sram_rdata), .data_stall(data_stall),
        .longest_stall(longest_stall),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_uncached(mem_uncached),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        unc;
    } req_t;

    req_t        exp_req[$];
    logic [31:0] exp_i[$], exp_d[$];
    logic [31:0] last_d;
    int          total, bad, acc_cnt, fix_adel, fix_ddel;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream memory returns an address-derived word for every read.
    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return a ^ 32'h23DDBFC0;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    // Downstream responder: checks every presented request against the head of the queue.
    initial begin : slave
        int          adel, dcnt;
        logic        have_del, wait_data;
        logic [31:0] rd_val;
        req_t        got;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        have_del = 1'b0; wait_data = 1'b0; adel = 0; dcnt = 0; rd_val = '0;
        forever begin
            @(posedge clk); #1;
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b0;
            if (!resetn) begin
                wait_data = 1'b0;
                have_del  = 1'b0;
            end else if (wait_data) begin
                if (dcnt == 0) begin
                    mem_data_ok = 1'b1;
                    mem_rdata   = rd_val;
                    wait_data   = 1'b0;
                end else dcnt--;
            end else if (mem_req) begin
                got = {mem_addr, mem_wr, mem_wstrb, mem_wdata, mem_uncached};
                if (exp_req.size() == 0) chk("req_unexpected", 128'(got), 128'(0));
                else                     chk("req_fields", 128'(got), 128'(exp_req[0]));
                if (!have_del) begin
                    adel = (fix_adel >= 0) ? fix_adel : int'($urandom_range(0, 3));
                    have_del = 1'b1;
                end
                if (adel == 0) begin
                    mem_addr_ok = 1'b1;
                    have_del    = 1'b0;
                    wait_data   = 1'b1;
                    acc_cnt++;
                    dcnt   = (fix_ddel >= 0) ? fix_ddel : int'($urandom_range(0, 2));
                    rd_val = mem_wr ? $urandom : rd_of(mem_addr);
                    if (exp_req.size() > 0) void'(exp_req.pop_front());
                end else begin
                    adel--;
                    mem_data_ok = ($urandom_range(0, 2) == 0);
                    mem_rdata   = $urandom;
                end
            end
        end
    end

    // Stall monitor: a falling stall means the source's result is now presented.
    initial begin : monitor
        logic pi, pd;
        pi = 1'b0; pd = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                pi = 1'b0; pd = 1'b0;
            end else begin
                if (pi && !inst_stall) begin
                    if (exp_i.size() == 0) chk("inst_unexpected_done", 128'(inst_sram_rdata), 128'(0));
                    else chk("inst_rdata", 128'(inst_sram_rdata), 128'(exp_i.pop_front()));
                end
                if (pd && !data_stall) begin
                    if (exp_d.size() == 0) chk("data_unexpected_done", 128'(data_sram_rdata), 128'(0));
                    else chk("data_rdata", 128'(data_sram_rdata), 128'(exp_d.pop_front()));
                end
                pi = inst_stall;
                pd = data_stall;
            end
        end
    end

    // mode: 0 both together, 1 fetch only, 2 data only, 3 fetch then data one cycle later
    task automatic issue(input int mode, input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] wd, input logic [3:0] wen, input logic unc);
        req_t ri, rq;
        ri = '{addr: ia, wr: 1'b0, wstrb: 4'h0, wdata: 32'h0, unc: 1'b0};
        rq = '{addr: da, wr: (wen != 4'h0), wstrb: wen, wdata: wd, unc: unc};
        @(posedge clk); #1;
        inst_sram_addr = ia; data_sram_addr = da; data_sram_wdata = wd;
        data_sram_wen = wen; no_dcache = unc; longest_stall = 1'b1;
        if (mode != 1 && wen == 4'h0) last_d = rd_of(da);
        case (mode)
            0: begin
                exp_req.push_back(rq); exp_req.push_back(ri);
                exp_d.push_back(last_d); exp_i.push_back(rd_of(ia));
                inst_sram_en = 1'b1; data_sram_en = 1'b1;
            end
            1: begin
                exp_req.push_back(ri); exp_i.push_back(rd_of(ia));
                inst_sram_en = 1'b1;
            end
            2: begin
                exp_req.push_back(rq); exp_d.push_back(last_d);
                data_sram_en = 1'b1;
            end
            default: begin
                exp_req.push_back(ri); exp_req.push_back(rq);
                exp_i.push_back(rd_of(ia)); exp_d.push_back(last_d);
                inst_sram_en = 1'b1;
                @(posedge clk); #1;
                data_sram_en = 1'b1;
            end
        endcase
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while ((inst_stall || data_stall) && n < 300);
        if (inst_stall || data_stall) chk({nm, "_timeout"}, 128'(1), 128'(0));
    endtask

    task automatic end_step();
        @(posedge clk); #1;
        inst_sram_en = 1'b0; data_sram_en = 1'b0; longest_stall = 1'b0;
        @(posedge clk); #1;
        longest_stall = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, cnt, c0;
        logic [31:0] a;
        total = 0; bad = 0; acc_cnt = 0; fix_adel = -1; fix_ddel = -1; last_d = '0;
        resetn = 1'b0; inst_sram_en = 1'b0; data_sram_en = 1'b0; no_dcache = 1'b0;
        longest_stall = 1'b1; inst_sram_addr = '0; data_sram_addr = '0;
        data_sram_wdata = '0; data_sram_wen = '0;
        #23;
        chk("reset_outputs", 128'({mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, mem_uncached,
            inst_sram_rdata, data_sram_rdata, inst_stall, data_stall}), 128'(0));
        @(posedge clk); #1; resetn = 1'b1;

        // Single fetch at minimum latency: stall high for exactly three cycles.
        fix_adel = 0; fix_ddel = 0;
        issue(1, 32'h1FC00000, 32'h0, 32'h0, 4'h0, 1'b0);
        cnt = 0;
        do begin @(negedge clk); if (inst_stall) cnt++; end while (inst_stall && cnt < 50);
        chk("fetch_stall_cycles", 128'(cnt), 128'(3));
        chk("fetch_rdata_value", 128'(inst_sram_rdata), 128'(32'h3C1DBFC0));
        end_step();

        // Fetch and load together: data is issued first.
        issue(0, 32'h1FC00004, 32'h00001000, 32'h0, 4'h0, 1'b0);
        wait_idle("both");
        end_step();

        // Uncached partial store leaves the load result untouched.
        issue(2, 32'h0, 32'h00001002, 32'h0000ABCD, 4'b0011, 1'b1);
        wait_idle("store");
        chk("store_keeps_rdata", 128'(data_sram_rdata), 128'(rd_of(32'h00001000)));
        end_step();

        // Long freeze after a fetch: no re-issue until the pipeline advances.
        issue(1, 32'h1FC00008, 32'h0, 32'h0, 4'h0, 1'b0);
        wait_idle("freeze");
        c0 = acc_cnt;
        repeat (10) @(negedge clk);
        chk("freeze_no_reissue", 128'(acc_cnt), 128'(c0));
        @(posedge clk); #1;
        longest_stall = 1'b0;
        exp_req.push_back('{addr: 32'h1FC00008, wr: 1'b0, wstrb: 4'h0, wdata: 32'h0, unc: 1'b0});
        exp_i.push_back(rd_of(32'h1FC00008));
        @(posedge clk); #1;
        longest_stall = 1'b1;
        @(negedge clk);
        chk("done_cleared_on_advance", 128'(inst_stall), 128'(1));
        wait_idle("refetch");
        end_step();

        // Delayed address accept with spurious data_ok while waiting.
        fix_adel = 4; fix_ddel = 1;
        issue(2, 32'h0, 32'h00002004, 32'h55AA55AA, 4'h0, 1'b0);
        wait_idle("slow_accept");
        end_step();

        // Asynchronous reset while the load waits for data.
        fix_adel = 0; fix_ddel = 6;
        c0 = acc_cnt;
        issue(2, 32'h0, 32'h00002008, 32'h12345678, 4'h0, 1'b0);
        n = 0;
        while (acc_cnt == c0 && n < 50) begin @(negedge clk); n++; end
        chk("reset_test_accept", 128'(acc_cnt != c0), 128'(1));
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        chk("async_reset_outputs", 128'({mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, mem_uncached,
            inst_sram_rdata, data_sram_rdata, inst_stall, data_stall}), 128'(0));
        exp_req.delete(); exp_i.delete(); exp_d.delete();
        last_d = '0;
        inst_sram_en = 1'b0; data_sram_en = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        fix_adel = -1; fix_ddel = -1;
        issue(0, 32'h1FC00010, 32'h0000200C, 32'h0, 4'h0, 1'b0);
        wait_idle("post_reset");
        end_step();

        // Randomized mix of sources, stores, delays and freeze lengths.
        for (int s = 0; s < 60; s++) begin
            a = $urandom & 32'hFFFF_FFFC;
            issue(int'($urandom_range(0, 3)), a, $urandom & 32'hFFFF_FFFC, $urandom,
                  ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                  1'($urandom_range(0, 1)));
            wait_idle("random");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            end_step();
        end

        repeat (5) @(negedge clk);
        chk("queues_drained", 128'(exp_req.size() + exp_i.size() + exp_d.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
